writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/riscv_pkg.sv | 14 +
 rtl/writeback_queue_if.sv | 26 ++
 rtl/writeback_queue_fwd_match.sv | 32 +++
 rtl/writeback_queue.sv | 103 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback path: data width, register address
// width and the {rd, data} entry carried by the writeback queue.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Producer/consumer bundle for the writeback queue: two write requests in, one
// register-file write port out.
interface writeback_queue_if;
  import riscv_pkg::*;

  logic      mem_valid;
  reg_addr_t mem_rd;
  xlen_t     mem_data;
  logic      alu_valid;
  reg_addr_t alu_rd;
  xlen_t     alu_data;
  logic      in_ready;
  logic      WriteEnable;
  reg_addr_t rd;
  xlen_t     data;

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    input  in_ready, WriteEnable, rd, data
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    output in_ready, WriteEnable, rd, data
  );
endinterface

// File: rtl/writeback_queue_fwd_match.sv
// Youngest-match lookup of one read address across the live queue entries.
// Entries are walked oldest to youngest from head, so the last hit wins.
module wb_fwd_match
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic      [DEPTH-1:0] valid,
  input  logic      [PTR_W-1:0] head,
  input  reg_addr_t             rs,
  output logic                  hit,
  output xlen_t                 hit_data
);

  // NOTE: every output gets a default before the loop, otherwise the no-match
  // path would hold its old value and infer a latch.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (rs != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (valid[head + PTR_W'(k)] && entries[head + PTR_W'(k)].rd == rs) begin
          hit      = 1'b1;
          hit_data = entries[head + PTR_W'(k)].data;
        end
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Pending register-file write queue: accepts up to two results per cycle (mem
// before alu), retires one per cycle, and forwards the youngest pending value.
module writeback_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  writeback_queue_if.slave  bus,
  input  reg_addr_t         rs1,
  input  reg_addr_t         rs2,
  output logic              fwd1_hit,
  output xlen_t             fwd1_data,
  output logic              fwd2_hit,
  output xlen_t             fwd2_data,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  wb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] valid;
  ptr_t                  head;
  ptr_t                  tail;
  cnt_t                  count;

  logic mem_req, alu_req;
  logic push_mem, push_alu, pop;
  logic mem_drop, alu_drop;
  ptr_t alu_slot;

  // rd=0 requests are discarded outright and never reach the overflow logic.
  assign mem_req  = rst && bus.mem_valid && (bus.mem_rd != '0);
  assign alu_req  = rst && bus.alu_valid && (bus.alu_rd != '0);

  assign bus.in_ready = (count <= cnt_t'(DEPTH - 2));

  assign push_mem = mem_req && bus.in_ready;
  assign push_alu = alu_req && bus.in_ready;
  assign mem_drop = mem_req && !bus.in_ready;
  assign alu_drop = alu_req && !bus.in_ready;
  assign alu_slot = tail + ptr_t'(push_mem);

  // Write port is gated by rst so an entry flushed by reset is never committed.
  assign pop             = rst && (count != '0);
  assign bus.WriteEnable = pop;
  assign bus.rd          = pop ? entries[head].rd   : '0;
  assign bus.data        = pop ? entries[head].data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      overflow <= 1'b0;
    end else begin
      head  <= head + ptr_t'(pop);
      tail  <= tail + ptr_t'(push_mem) + ptr_t'(push_alu);
      count <= count - cnt_t'(pop) + cnt_t'(push_mem) + cnt_t'(push_alu);
      if (mem_drop || alu_drop) overflow <= 1'b1;
      // Push slots never alias head: a push needs two free entries.
      if (pop)      valid[head]     <= 1'b0;
      if (push_mem) valid[tail]     <= 1'b1;
      if (push_alu) valid[alu_slot] <= 1'b1;
    end
  end

  // NOTE: the payload array is not cleared on reset; valid and count decide
  // whether a slot is live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (push_mem) entries[tail]     <= '{rd: bus.mem_rd, data: bus.mem_data};
      if (push_alu) entries[alu_slot] <= '{rd: bus.alu_rd, data: bus.alu_data};
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries  (entries),
    .valid    (valid),
    .head     (head),
    .rs       (rs1),
    .hit      (fwd1_hit),
    .hit_data (fwd1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries  (entries),
    .valid    (valid),
    .head     (head),
    .rs       (rs2),
    .hit      (fwd2_hit),
    .hit_data (fwd2_data)
  );

endmodule
